// File: rtl/mem_responder_if.sv
// Cache-to-memory request bus for mem_responder.
// MErr is present only when MEM_ERR_EN is defined.
interface mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              MStrobe;
  logic              MRW;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MDataIn;
  logic [DATA_W-1:0] MDataOut;
  logic              MRdy;
`ifdef MEM_ERR_EN
  logic              MErr;
`endif

  modport master (
    output MStrobe,
    output MRW,
    output MAddr,
    output MDataIn,
`ifdef MEM_ERR_EN
    input  MErr,
`endif
    input  MDataOut,
    input  MRdy
  );

  modport slave (
    input  MStrobe,
    input  MRW,
    input  MAddr,
    input  MDataIn,
`ifdef MEM_ERR_EN
    output MErr,
`endif
    output MDataOut,
    output MRdy
  );
endinterface

// File: rtl/mem_responder.sv
// Slow main-memory responder: captures one request, waits WAIT_CYCLES, accesses the array, pulses MRdy.
// Optional MEM_ERR_EN adds MErr, flagging strobes that arrive while a request is in flight.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_responder_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdy_q, rdy_d;
  logic                mem_we_s;
`ifdef MEM_ERR_EN
  logic                err_q, err_d;
`endif

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  // State, request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state, request capture and access decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rdy_d    = 1'b0;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.MStrobe) begin
          rw_d    = bus.MRW;
          addr_d  = bus.MAddr;
          wdata_d = bus.MDataIn;
          cnt_d   = 8'(WAIT_CYCLES);
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d   = cnt_q - 8'd1;
          state_d = S_WAIT;
        end else begin
          // rdy_q is registered, so raising it here makes it a Moore output of S_DONE.
          state_d = S_DONE;
          rdy_d   = 1'b1;
          if (rw_q) begin
            rdata_d = mem[addr_q];
          end else begin
            mem_we_s = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Backing store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[addr_q] <= wdata_q;
    end
  end

`ifdef MEM_ERR_EN
  // Strobe while busy is dropped but flagged for one cycle.
  always_comb begin
    err_d = 1'b0;
    if (bus.MStrobe && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.MErr = err_q;
`endif

  assign bus.MDataOut = rdata_q;
  assign bus.MRdy     = rdy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, hand-written corner sequences,
// and randomized traffic against an array-based reference model.
module tb_mem_responder;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();

  mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] model_mem [256];
  logic [31:0] model_dout;
  logic [7:0]  written [$];
  int          chk_cnt;
  int          pass_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic scramble();
    bus.MAddr   = 8'($urandom);
    bus.MDataIn = $urandom;
    bus.MRW     = 1'($urandom);
  endtask

  // Called at a negedge; returns at the negedge right after MRdy falls (next strobe lands at E0+W+3).
  task automatic do_req(input logic rw, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_dout, input string tag);
    int lat;
    bus.MStrobe = 1'b1;
    bus.MRW     = rw;
    bus.MAddr   = addr;
    bus.MDataIn = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.MStrobe = 1'b0;
    scramble();
    lat = 0;
    for (int k = 1; k <= W + 10 && lat == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.MRdy) lat = k;
      else check({tag, "_dout_before_access"}, bus.MDataOut, model_dout);
      scramble();
    end
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
    check({tag, "_dout"}, bus.MDataOut, exp_dout);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rdy_one_cycle"}, {31'd0, bus.MRdy}, 32'd0);
    check({tag, "_dout_held"}, bus.MDataOut, exp_dout);
    if (rw) model_dout = model_mem[addr];
    else model_mem[addr] = wdata;
  endtask

  initial begin
    int rdy_cnt;
    int err_cnt;
    logic [7:0]  a;
    logic [31:0] d;

    vecs[0] = '{1'b0, 8'h12, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b1, 8'h12, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 8'h00, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 8'hFF, 32'h5A5A5A5A, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 8'h00, 32'h00000000, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 8'hFF, 32'h00000000, 32'h5A5A5A5A};

    chk_cnt = 0;
    pass_cnt = 0;
    model_dout = 32'd0;
    rst_n = 1'b0;
    bus.MStrobe = 1'b0;  bus.MRW = 1'b0;  bus.MAddr = 8'd0;  bus.MDataIn = 32'd0;
    bus0.MStrobe = 1'b0; bus0.MRW = 1'b0; bus0.MAddr = 8'd0; bus0.MDataIn = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_rdy", {31'd0, bus.MRdy}, 32'd0);
    check("reset_dout", bus.MDataOut, 32'd0);
`ifdef MEM_ERR_EN
    check("reset_err", {31'd0, bus.MErr}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_req(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
      written.push_back(vecs[i].addr);
    end

    // Strobe during WAIT: write to 0x00 must be dropped.
    bus.MStrobe = 1'b1; bus.MRW = 1'b1; bus.MAddr = 8'h12;
    @(posedge clk);
    @(negedge clk);
    bus.MStrobe = 1'b1; bus.MRW = 1'b0; bus.MAddr = 8'h00; bus.MDataIn = 32'hFFFF0000;
    rdy_cnt = 0;
    err_cnt = 0;
    for (int k = 1; k <= W + 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.MStrobe = 1'b0;
      if (bus.MRdy) rdy_cnt++;
`ifdef MEM_ERR_EN
      if (bus.MErr) err_cnt++;
`endif
    end
    check("drop_rdy_count", 32'(rdy_cnt), 32'd1);
`ifdef MEM_ERR_EN
    check("drop_err_count", 32'(err_cnt), 32'd1);
`endif
    check("drop_dout", bus.MDataOut, 32'hDEADBEEF);
    model_dout = 32'hDEADBEEF;
    do_req(1'b1, 8'h00, 32'd0, 32'hA5A5A5A5, "drop_read00");

    // Reset two cycles into a pending write discards it.
    do_req(1'b0, 8'h20, 32'h11111111, model_dout, "rst_prewrite");
    bus.MStrobe = 1'b1; bus.MRW = 1'b0; bus.MAddr = 8'h20; bus.MDataIn = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    bus.MStrobe = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rst_mid_rdy", {31'd0, bus.MRdy}, 32'd0);
      check("rst_mid_dout", bus.MDataOut, 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_dout = 32'd0;
    @(negedge clk);
    do_req(1'b1, 8'h20, 32'd0, 32'h11111111, "rst_readback");
    written.push_back(8'h20);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = 8'($urandom);
        d = $urandom;
        do_req(1'b0, a, d, model_dout, "rand_wr");
        written.push_back(a);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        do_req(1'b1, a, 32'd0, model_mem[a], "rand_rd");
      end
    end

    // WAIT_CYCLES=0 instance: held strobe reads 0x05 twice.
    bus0.MStrobe = 1'b1; bus0.MRW = 1'b0; bus0.MAddr = 8'h05; bus0.MDataIn = 32'hC0FFEE00;
    @(posedge clk);
    @(negedge clk);
    bus0.MStrobe = 1'b0;
    repeat (3) @(negedge clk);
    bus0.MStrobe = 1'b1; bus0.MRW = 1'b1; bus0.MAddr = 8'h05;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("w0_rdy_edge%0d", e), {31'd0, bus0.MRdy}, (e == 2 || e == 5) ? 32'd1 : 32'd0);
    end
    bus0.MStrobe = 1'b0;
    check("w0_dout", bus0.MDataOut, 32'hC0FFEE00);
    @(negedge clk);
    check("w0_quiet", {31'd0, bus0.MRdy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
